disp_scan: RTL and testbench
============================

DISP_SCAN -- requirements
Module: disp_scan

Interface
REQ-001 Parameter COLS, default 40: characters per display line; legal range 1..1024.
REQ-002 Parameter ROWS, default 4: lines per frame; COLS*ROWS SHALL be at most 1024.
REQ-003 Parameter BASE, default 0: first RAM address of the frame; BASE+COLS*ROWS-1 SHALL be at most 1023.
REQ-004 clk  in  1  single clock; display RAM read port runs on this clock.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to scan one frame.
REQ-007 busy  out  1  high from the cycle after an accepted start until frame_done.
REQ-008 read_address  out  10  display RAM read address.
REQ-009 q  in  8  display RAM read data; q reflects the read_address driven two clocks earlier.
REQ-010 out_data  out  8  character byte to the downstream consumer.
REQ-011 out_valid  out  1  out_data/out_sol/out_eof are valid.
REQ-012 out_ready  in  1  consumer accepts; transfer occurs on a clk edge with out_valid and out_ready both high.
REQ-013 out_sol  out  1  current byte is column 0 of a line.
REQ-014 out_eof  out  1  current byte is the last byte of the frame.
REQ-015 frame_done  out  1  one-cycle pulse when the frame is fully transferred.

Function
REQ-016 States: IDLE, RUN, DRAIN; the block leaves reset in IDLE.
REQ-017 In IDLE, start=1 SHALL load row=0, col=0, addr=BASE and enter RUN; start while not IDLE SHALL be ignored.
REQ-018 In RUN, a read SHALL be issued in a cycle only when fifo_count + inflight < 4.
- Each issued read drives read_address=addr and tags the read with sol=(col==0) and eof=(last address).
- It then advances addr by 1 and col by 1.
- col wraps to 0 with row+1 at col==COLS-1.
REQ-019 inflight is a 2-stage valid/tag pipeline matching the RAM latency; a stage exiting the pipeline SHALL write {q, sol, eof} into the FIFO in that cycle.
REQ-020 The FIFO is 4 entries of 10 bits; simultaneous push and pop SHALL keep count unchanged; overflow SHALL be impossible by the REQ-018 credit rule.
REQ-021 Output is the FIFO head: out_valid = (count != 0); pop on out_valid & out_ready; output fields SHALL NOT change while out_valid=1 and out_ready=0.
REQ-022 Issuing the eof-tagged read SHALL move RUN to DRAIN; no further reads are issued in DRAIN.
REQ-023 DRAIN to IDLE SHALL occur on the edge where the eof byte is popped; frame_done SHALL be high for exactly the following cycle, and busy SHALL be low in that same cycle.
REQ-024 read_address SHALL hold its last issued value when no read is issued.
REQ-025 With out_ready held high, the first out_valid SHALL occur 3 cycles after start is sampled, and bytes SHALL then stream one per cycle.
REQ-026 Frame length 1 (COLS=ROWS=1): the single byte SHALL carry out_sol=1 and out_eof=1.
REQ-027 Address arithmetic is 10-bit unsigned; wrap past 1023 SHALL NOT occur given REQ-003.

Reset
REQ-028 Reset SHALL force state IDLE, FIFO count 0, inflight pipeline empty, row/col 0, read_address=BASE, and out_valid, out_sol, out_eof, busy, frame_done all 0; out_data SHALL be 0.
REQ-029 Reset asserted mid-frame SHALL discard all in-flight and buffered data; no frame_done is emitted for the aborted frame.

Verification
REQ-030 COLS=4, ROWS=2, BASE=0x10, RAM[i]=i, out_ready=1, pulse start -> bytes 0x10..0x17 on consecutive cycles; out_sol on 0x10 and 0x14; out_eof on 0x17; frame_done one cycle after the 0x17 transfer.
REQ-031 Same setup with out_ready low for 10 cycles from start -> exactly 4 bytes are buffered, read_address stops advancing, and the sequence resumes without loss or duplication when out_ready rises.
REQ-032 out_ready toggled randomly 1/0 over the frame -> output byte order and sol/eof flags are identical to REQ-030; out_data is stable whenever out_valid=1 and out_ready=0.
REQ-033 Second start pulse while busy -> ignored; exactly one frame of 8 bytes is produced.
REQ-034 Reset asserted after the 3rd transfer -> outputs match REQ-028 within the same cycle; a new start then produces the full frame from 0x10.
REQ-035 COLS=1, ROWS=1, RAM[0]=0xA5 -> single transfer 0xA5 with out_sol=1, out_eof=1, followed by a frame_done pulse.

Source files
------------

// File: rtl/disp_scan.sv
// rtl/disp_scan.sv - character display frame scanner: RAM reads through a 4-deep credit FIFO to a ready/valid stream
module disp_scan #(
    parameter int COLS = 40,
    parameter int ROWS = 4,
    parameter int BASE = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic [9:0] read_address,
    input  logic [7:0] q,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_sol,
    output logic       out_eof,
    output logic       frame_done
);

    localparam logic [9:0] BASE_ADDR = 10'(BASE);
    localparam logic [9:0] COL_LAST  = 10'(COLS - 1);
    localparam logic [9:0] ROW_LAST  = 10'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [9:0]  addr, last_addr, row, col;
    logic        issue, last_cell, push, pop, eof_pop;
    logic        s1_v, s1_sol, s1_eof, s2_v, s2_sol, s2_eof;
    logic [9:0]  fifo_mem [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  fifo_count;
    logic [9:0]  head;
    logic        credit_ok;

    // FIFO head and handshake decode; stored entry layout is {data, sol, eof}
    always_comb begin
        head      = fifo_mem[rd_ptr];
        out_valid = (fifo_count != 3'd0);
        pop       = out_valid & out_ready;
        push      = s2_v;
        eof_pop   = pop & head[0];
        out_data  = out_valid ? head[9:2] : 8'h00;
        out_sol   = out_valid & head[1];
        out_eof   = out_valid & head[0];
        last_cell = (row == ROW_LAST) && (col == COL_LAST);
        // reads in flight plus bytes buffered can never exceed the FIFO depth
        credit_ok = (fifo_count + 3'(s1_v) + 3'(s2_v)) < 3'd4;
        busy      = (state_q != IDLE);
    end

    // next-state and read-issue decision
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            IDLE:  if (start) state_d = RUN;
            RUN: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (last_cell) state_d = DRAIN;
                end
            end
            DRAIN: if (eof_pop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        read_address = issue ? addr : last_addr;
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // address and row/column scan counters; last_addr holds the RAM address between reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr      <= BASE_ADDR;
            last_addr <= BASE_ADDR;
            row       <= '0;
            col       <= '0;
        end else if (state_q == IDLE && start) begin
            addr <= BASE_ADDR;
            row  <= '0;
            col  <= '0;
        end else if (issue) begin
            last_addr <= addr;
            addr      <= addr + 10'd1;
            if (col == COL_LAST) begin
                col <= '0;
                row <= row + 10'd1;
            end else begin
                col <= col + 10'd1;
            end
        end
    end

    // two-stage tag pipeline aligned with the RAM read latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_v <= 1'b0; s1_sol <= 1'b0; s1_eof <= 1'b0;
            s2_v <= 1'b0; s2_sol <= 1'b0; s2_eof <= 1'b0;
        end else begin
            s1_v   <= issue;
            s1_sol <= issue && (col == 10'd0);
            s1_eof <= issue && last_cell;
            s2_v   <= s1_v;
            s2_sol <= s1_sol;
            s2_eof <= s1_eof;
        end
    end

    // FIFO storage; contents are don't-care while count is zero, so no reset needed
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {q, s2_sol, s2_eof};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 3'd1;
                2'b01:   fifo_count <= fifo_count - 3'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // one-cycle completion pulse after the eof byte leaves
    always_ff @(posedge clk or posedge reset) begin
        if (reset) frame_done <= 1'b0;
        else       frame_done <= (state_q == DRAIN) && eof_pop;
    end

endmodule

// File: tb/tb_disp_scan.sv
// tb/tb_disp_scan.sv - scoreboard bench for disp_scan (4x2 frame at 0x10 and 1x1 frame)
module tb_disp_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_start, a_busy, a_valid, a_ready, a_sol, a_eof, a_fd;
    logic [9:0] a_addr, a_ra1;
    logic [7:0] a_q, a_data;
    logic       b_start, b_busy, b_valid, b_ready, b_sol, b_eof, b_fd;
    logic [9:0] b_addr, b_ra1;
    logic [7:0] b_q, b_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [9:0] qa[$];
    logic [9:0] qb[$];
    int   cyc = 0;
    int   xfer_a = 0, first_cyc = 0, last_cyc = 0;
    logic seen_fd_a = 1'b0, seen_fd_b = 1'b0, fd_pending = 1'b0;
    logic prev_stall = 1'b0;
    logic [9:0] prev_out = '0;

    always #5 clk = ~clk;

    disp_scan #(.COLS(4), .ROWS(2), .BASE(16)) dut_a (
        .clk(clk), .reset(rst), .start(a_start), .busy(a_busy),
        .read_address(a_addr), .q(a_q), .out_data(a_data), .out_valid(a_valid),
        .out_ready(a_ready), .out_sol(a_sol), .out_eof(a_eof), .frame_done(a_fd)
    );

    disp_scan #(.COLS(1), .ROWS(1), .BASE(0)) dut_b (
        .clk(clk), .reset(rst), .start(b_start), .busy(b_busy),
        .read_address(b_addr), .q(b_q), .out_data(b_data), .out_valid(b_valid),
        .out_ready(b_ready), .out_sol(b_sol), .out_eof(b_eof), .frame_done(b_fd)
    );

    // display RAMs with two-clock read latency
    always @(posedge clk) begin
        a_ra1 <= a_addr;
        a_q   <= a_ra1[7:0];
        b_ra1 <= b_addr;
        b_q   <= (b_ra1 == 10'd0) ? 8'hA5 : b_ra1[7:0];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // output monitor: scoreboard pops, stall stability, frame_done timing
    always @(negedge clk) begin
        logic [9:0] exp;
        cyc++;
        if (rst) begin
            prev_stall = 1'b0;
            fd_pending = 1'b0;
        end else begin
            if (a_fd || fd_pending) check("frame_done_a", a_fd, fd_pending);
            if (a_fd) begin
                check("busy_at_done", a_busy, 0);
                seen_fd_a = 1'b1;
            end
            if (prev_stall) check("stall_stable", {a_valid, a_data, a_sol, a_eof}, {1'b1, prev_out});
            fd_pending = 1'b0;
            if (a_valid && a_ready) begin
                if (qa.size() == 0) begin
                    check("unexpected_a", {a_data, a_sol, a_eof}, 10'h3ff);
                end else begin
                    exp = qa.pop_front();
                    check("xfer_a", {a_data, a_sol, a_eof}, exp);
                end
                if (xfer_a == 0) first_cyc = cyc;
                last_cyc = cyc;
                xfer_a++;
                fd_pending = a_eof;
            end
            prev_stall = a_valid && !a_ready;
            prev_out   = {a_data, a_sol, a_eof};
            if (b_fd) seen_fd_b = 1'b1;
            if (b_valid && b_ready) begin
                if (qb.size() == 0) begin
                    check("unexpected_b", {b_data, b_sol, b_eof}, 10'h3ff);
                end else begin
                    exp = qb.pop_front();
                    check("xfer_b", {b_data, b_sol, b_eof}, exp);
                end
            end
        end
    end

    task automatic push_frame_a();
        for (int i = 0; i < 8; i++)
            qa.push_back({8'(16 + i), (i % 4) == 0, i == 7});
        xfer_a    = 0;
        seen_fd_a = 1'b0;
    endtask

    task automatic pulse_a();
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
    endtask

    task automatic wait_done_a(input int budget);
        int n = 0;
        while (!seen_fd_a && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!seen_fd_a) check("timeout_a", 0, 1);
        check("queue_a_empty", qa.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        logic [9:0] addr1;
        rst = 1'b1; a_start = 1'b0; b_start = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", a_busy, 0);
        check("rst_valid", a_valid, 0);
        check("rst_flags", {a_sol, a_eof, a_fd}, 0);
        check("rst_data", a_data, 0);
        check("rst_addr", a_addr, 10'h010);
        rst = 1'b0;
        @(posedge clk); #1;

        // full frame streaming, first-byte latency
        push_frame_a();
        pulse_a();
        n = 0;
        while (!a_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, 3);
        wait_done_a(60);
        check("stream_span", last_cyc - first_cyc, 7);
        check("stream_count", xfer_a, 8);

        // backpressure for 10 cycles from start
        a_ready = 1'b0;
        push_frame_a();
        pulse_a();
        repeat (5) @(posedge clk);
        #1 addr1 = a_addr;
        repeat (4) @(posedge clk);
        #1;
        check("bp_addr_early", addr1, 10'h013);
        check("bp_addr_late", a_addr, 10'h013);
        check("bp_head", {a_valid, a_data}, {1'b1, 8'h10});
        check("bp_no_xfer", xfer_a, 0);
        a_ready = 1'b1;
        wait_done_a(60);

        // random backpressure
        push_frame_a();
        pulse_a();
        fork
            wait_done_a(400);
            begin
                for (int k = 0; k < 300 && !seen_fd_a; k++) begin
                    a_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
        join
        a_ready = 1'b1;
        check("rand_count", xfer_a, 8);

        // second start while busy is ignored
        push_frame_a();
        pulse_a();
        repeat (2) @(posedge clk);
        #1 pulse_a();
        wait_done_a(60);
        repeat (10) @(posedge clk);
        #1;
        check("single_frame", xfer_a, 8);
        check("no_extra_valid", a_valid, 0);

        // reset after the third transfer, then a clean frame
        push_frame_a();
        pulse_a();
        n = 0;
        while (xfer_a < 3 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("reached_3", xfer_a, 3);
        rst = 1'b1;
        #1;
        check("mid_rst_outs", {a_valid, a_sol, a_eof, a_busy, a_fd}, 0);
        check("mid_rst_data", a_data, 0);
        check("mid_rst_addr", a_addr, 10'h010);
        qa.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        push_frame_a();
        pulse_a();
        wait_done_a(60);
        check("after_rst_count", xfer_a, 8);

        // single-cell frame
        qb.push_back({8'hA5, 1'b1, 1'b1});
        seen_fd_b = 1'b0;
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        n = 0;
        while (!seen_fd_b && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_b", seen_fd_b, 1);
        check("queue_b_empty", qb.size(), 0);
        check("idle_b", b_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
